sm4_dual_sched: RTL
===================

Name: sm4_dual_sched

Overview:
- Controller that shares one pipelined SM4 core (MODE fixed per instance) between two block requesters.
- Round-robin arbitration of input blocks into the core.
- Tracks in-flight blocks with a tag FIFO and routes each core result back to its requester in order.
- Sequences key changes: stops issue, drains the pipeline, pulses MK_VALID to the core, then waits out key expansion before issuing again.

Parameters:
- MAX_INFLIGHT, 32: max blocks in the core at once; power of two, 2..64; sets tag FIFO depth.
- KEYEXP_CYCLES, 40: wait cycles after the MK_VALID pulse before the first issue under the new key; minimum 1.

Ports:
- CLK_i  in  1  clock.
- RST_i  in  1  synchronous active-high reset.
- KEY_i  in  128  new master key.
- KEY_VALID_i  in  1  key load request; accepted when KEY_BUSY_o=0.
- KEY_BUSY_o  out  1  key change in progress or no key loaded.
- REQ0_DAT_i  in  128  requester 0 block.
- REQ0_VALID_i  in  1  requester 0 valid.
- REQ0_READY_o  out  1  requester 0 accepted this cycle.
- REQ1_DAT_i, REQ1_VALID_i, REQ1_READY_o: same as requester 0, for requester 1.
- RSP0_DAT_o  out  128  result for requester 0.
- RSP0_VALID_o  out  1  one-cycle result strobe; no backpressure.
- RSP1_DAT_o, RSP1_VALID_o: same as requester 0, for requester 1.
- CORE_MK_o  out  128  key to core.
- CORE_MK_VALID_o  out  1  one-cycle key strobe to core.
- CORE_DAT_o  out  128  block to core.
- CORE_DAT_VALID_o  out  1  block strobe to core.
- CORE_DAT_i  in  128  core result.
- CORE_DAT_READY_i  in  1  core result strobe.
- ERR_o  out  1  sticky: result received with empty tag FIFO.
- STAT0_o  out  16  requester 0 issue count (optional feature).
- STAT1_o  out  16  requester 1 issue count (optional feature).

Behaviour:
- Reset: state=IDLE. All outputs 0 except KEY_BUSY_o=1. Counters, FIFO pointers and ERR_o cleared. last_grant=1.
- Reset mid-operation discards all in-flight tags. Core results arriving after reset set ERR_o.
- FSM states:
  - IDLE: no key loaded. KEY_VALID_i latches KEY_i and goes to KEYLOAD.
  - KEYLOAD: one cycle. CORE_MK_VALID_o=1 with the latched key on CORE_MK_o. Load wait counter with KEYEXP_CYCLES. Go to KEYWAIT.
  - KEYWAIT: decrement counter each cycle; at 0, go to RUN. KEY_BUSY_o=0 in RUN.
  - RUN: issue allowed. KEY_VALID_i latches KEY_i; go to KEYLOAD if inflight==0, else DRAIN.
  - DRAIN: no issue; results still returned. When inflight==0, go to KEYLOAD.
- KEY_BUSY_o=1 in IDLE, KEYLOAD, KEYWAIT and DRAIN. KEY_VALID_i is ignored while busy, except in IDLE.
- Issue eligibility: state==RUN, KEY_VALID_i==0 and inflight<MAX_INFLIGHT. A pop in the same cycle does not relax the full check.
- Arbitration:
  - REQn_READY_o is combinational and asserted only for the winner.
  - If both valid, the winner is the requester not equal to last_grant; otherwise the sole valid requester wins.
  - last_grant updates on each handshake.
  - Handshake is REQn_VALID_i & REQn_READY_o. The requester holds data until handshake.
- Issue path:
  - On handshake, register the data into CORE_DAT_o and assert CORE_DAT_VALID_o the next cycle for exactly one cycle. Issue latency is 1.
  - Push the requester id into the tag FIFO and increment inflight.
- Return path:
  - On CORE_DAT_READY_i, pop a tag.
  - Next cycle, drive RSPtag_DAT_o=CORE_DAT_i and pulse RSPtag_VALID_o. The other RSP_VALID is 0. Return latency is 1.
  - RSPn_DAT_o holds its last value between strobes.
- Simultaneous push and pop: inflight unchanged; FIFO read and write in the same cycle are both correct.
- Pop with empty FIFO: no pop, no RSP strobe, ERR_o=1 until reset.
- inflight is ceil(log2(MAX_INFLIGHT))+1 bits wide. It never exceeds MAX_INFLIGHT.
- Sustained throughput is one block per cycle across both requesters.

Optional Feature:
- Macro SM4_SCHED_STATS_EN.
- Defined: STAT0_o/STAT1_o increment on each handshake of the respective requester. They saturate at 16'hFFFF and clear on reset only.
- Undefined: STAT0_o/STAT1_o tied to 0; no counter flops.

Test Plan:
- Basic round trip:
  - Stimulus: reset; KEY=0123456789abcdeffedcba9876543210; wait KEY_BUSY_o=0; REQ0 block 0123456789abcdeffedcba9876543210.
  - Response: CORE_MK_VALID_o exactly one pulse; no issue for KEYEXP_CYCLES after it; RSP0 = 681edf34d206965e86b3e94f536e4246 (MODE=0 core); RSP1_VALID_o never set.
- Fairness:
  - Stimulus: both requesters valid continuously for 8 cycles.
  - Response: grants alternate 0,1,0,1,...; 8 core issues back to back; each RSP strobe goes to its originating requester in issue order.
- Backpressure:
  - Stimulus: MAX_INFLIGHT=4 with a core stub of latency 10; REQ0 valid continuously.
  - Response: exactly 4 issues, then READY low until the first result, then one issue per result.
- Rekey:
  - Stimulus: KEY_VALID_i while 3 blocks are in flight.
  - Response: READY low that cycle and after; 3 results return; then the MK pulse; RUN resumes after KEYEXP_CYCLES; a second KEY_VALID_i during DRAIN is ignored.
- Error path:
  - Stimulus: CORE_DAT_READY_i with nothing in flight.
  - Response: ERR_o=1 permanently; no RSP strobe; cleared by RST_i.
- Stats (SM4_SCHED_STATS_EN):
  - Stimulus: 5 REQ0 and 3 REQ1 handshakes.
  - Response: STAT0_o=5, STAT1_o=3; both 0 without the macro.

Source files
------------

// File: rtl/sm4_dual_sched.sv
`timescale 1ns/1ps
// Shares one pipelined SM4 core between two requesters: round-robin issue, in-order result routing, key-change sequencing.
// Latency: 1 cycle handshake->CORE_DAT_VALID_o, 1 cycle CORE_DAT_READY_i->RSPn_VALID_o.
// Backpressure: REQn_READY_o low when MAX_INFLIGHT outstanding or a key change is pending; results are never stalled.
// Optional: define SM4_SCHED_STATS_EN for saturating per-requester issue counters on STAT0_o/STAT1_o.
module sm4_dual_sched #(
    parameter int MAX_INFLIGHT  = 32,
    parameter int KEYEXP_CYCLES = 40
) (
    input  logic         CLK_i,
    input  logic         RST_i,
    input  logic [127:0] KEY_i,
    input  logic         KEY_VALID_i,
    output logic         KEY_BUSY_o,
    input  logic [127:0] REQ0_DAT_i,
    input  logic         REQ0_VALID_i,
    output logic         REQ0_READY_o,
    input  logic [127:0] REQ1_DAT_i,
    input  logic         REQ1_VALID_i,
    output logic         REQ1_READY_o,
    output logic [127:0] RSP0_DAT_o,
    output logic         RSP0_VALID_o,
    output logic [127:0] RSP1_DAT_o,
    output logic         RSP1_VALID_o,
    output logic [127:0] CORE_MK_o,
    output logic         CORE_MK_VALID_o,
    output logic [127:0] CORE_DAT_o,
    output logic         CORE_DAT_VALID_o,
    input  logic [127:0] CORE_DAT_i,
    input  logic         CORE_DAT_READY_i,
    output logic         ERR_o,
    output logic [15:0]  STAT0_o,
    output logic [15:0]  STAT1_o
);
    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam int CW = $clog2(KEYEXP_CYCLES + 1);
    localparam logic [AW:0]   INF_MAX  = (AW+1)'(MAX_INFLIGHT);
    localparam logic [AW:0]   INF_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(KEYEXP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {S_IDLE, S_KEYLOAD, S_KEYWAIT, S_RUN, S_DRAIN} state_t;

    state_t              state, state_nxt;
    logic                key_latch;
    logic [127:0]        key_q;
    logic [CW-1:0]       wait_cnt;
    logic [AW:0]         inflight;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [MAX_INFLIGHT-1:0] tag_mem;
    logic                last_grant;
    logic                fifo_empty, issue_ok, grant0, grant1;
    logic                push, pop, push_id, pop_id;
    logic [127:0]        push_dat;

    assign fifo_empty = (inflight == '0);
    // A pop in the same cycle deliberately does not free a slot for issue.
    assign issue_ok   = (state == S_RUN) && !KEY_VALID_i && (inflight < INF_MAX);
    // Requester 1 wins when alone or when requester 0 was served last.
    assign grant1     = REQ1_VALID_i && (!REQ0_VALID_i || !last_grant);
    assign grant0     = REQ0_VALID_i && !grant1;
    assign REQ0_READY_o = issue_ok && grant0;
    assign REQ1_READY_o = issue_ok && grant1;
    assign push       = REQ0_READY_o || REQ1_READY_o;
    assign push_id    = REQ1_READY_o;
    assign push_dat   = REQ1_READY_o ? REQ1_DAT_i : REQ0_DAT_i;
    assign pop        = CORE_DAT_READY_i && !fifo_empty;
    assign pop_id     = tag_mem[rd_ptr];

    assign KEY_BUSY_o      = (state != S_RUN);
    assign CORE_MK_VALID_o = (state == S_KEYLOAD);
    assign CORE_MK_o       = key_q;

    // State register.
    always_ff @(posedge CLK_i) begin
        if (RST_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and key latch enable.
    always_comb begin
        state_nxt = state;
        key_latch = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (KEY_VALID_i) begin
                    key_latch = 1'b1;
                    state_nxt = S_KEYLOAD;
                end
            end
            S_KEYLOAD: state_nxt = S_KEYWAIT;
            // Counter reaches zero on the edge that leaves KEYWAIT.
            S_KEYWAIT: if (wait_cnt == CNT_ONE) state_nxt = S_RUN;
            S_RUN: begin
                if (KEY_VALID_i) begin
                    key_latch = 1'b1;
                    state_nxt = fifo_empty ? S_KEYLOAD : S_DRAIN;
                end
            end
            S_DRAIN: if (fifo_empty) state_nxt = S_KEYLOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Master key capture and key-expansion wait counter.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            key_q    <= '0;
            wait_cnt <= '0;
        end else begin
            if (key_latch) key_q <= KEY_i;
            if (state == S_KEYLOAD)      wait_cnt <= CNT_LOAD;
            else if (state == S_KEYWAIT) wait_cnt <= wait_cnt - CNT_ONE;
        end
    end

    // Tag FIFO pointers and in-flight count.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   inflight <= inflight + INF_ONE;
                2'b01:   inflight <= inflight - INF_ONE;
                default: ;
            endcase
        end
    end

    // Tag storage; contents are meaningless once the pointers are cleared.
    always_ff @(posedge CLK_i) begin
        if (push) tag_mem[wr_ptr] <= push_id;
    end

    // Issue register toward the core and round-robin history.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            CORE_DAT_o       <= '0;
            CORE_DAT_VALID_o <= 1'b0;
            last_grant       <= 1'b1;
        end else begin
            CORE_DAT_VALID_o <= push;
            if (push) begin
                CORE_DAT_o <= push_dat;
                last_grant <= push_id;
            end
        end
    end

    // Return routing by popped tag; sticky error on result with no tag.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            RSP0_DAT_o   <= '0;
            RSP1_DAT_o   <= '0;
            RSP0_VALID_o <= 1'b0;
            RSP1_VALID_o <= 1'b0;
            ERR_o        <= 1'b0;
        end else begin
            RSP0_VALID_o <= pop && !pop_id;
            RSP1_VALID_o <= pop && pop_id;
            if (pop && !pop_id) RSP0_DAT_o <= CORE_DAT_i;
            if (pop && pop_id)  RSP1_DAT_o <= CORE_DAT_i;
            if (CORE_DAT_READY_i && fifo_empty) ERR_o <= 1'b1;
        end
    end

`ifdef SM4_SCHED_STATS_EN
    logic [15:0] stat0_q, stat1_q;

    // Saturating per-requester handshake counters.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            if (REQ0_READY_o && stat0_q != 16'hFFFF) stat0_q <= stat0_q + 16'd1;
            if (REQ1_READY_o && stat1_q != 16'hFFFF) stat1_q <= stat1_q + 16'd1;
        end
    end

    assign STAT0_o = stat0_q;
    assign STAT1_o = stat1_q;
`else
    assign STAT0_o = '0;
    assign STAT1_o = '0;
`endif

endmodule
